// File: rtl/uart_periph.sv
// UART peripheral: register-bus responder with TX FIFO + 8N1 serialiser,
// 8N1 deserialiser into a one-byte RX holding register, and a status byte.
//
// Ports:
//   clk, rst        system clock, asynchronous active-low reset
//   uart_rd/uart_wr single-cycle read/write strobes
//   uart_addr       register select (0 data, 1 status, 2 W1C, 3 none)
//   uart_din        write data
//   uart_dout       RX holding register
//   uart_dout1      status {0,tx_ovf,frm_err,rx_ovr,tx_busy,tx_empty,
//                   tx_full,rx_valid}
//   uart_rxd        asynchronous serial input
//   uart_txd        serial output
module uart_periph #(
    parameter int CLKS_PER_BIT = 868,
    parameter int TX_DEPTH     = 4,
    parameter int DW           = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          uart_rd,
    input  logic          uart_wr,
    input  logic [1:0]    uart_addr,
    input  logic [DW-1:0] uart_din,
    output logic [DW-1:0] uart_dout,
    output logic [DW-1:0] uart_dout1,
    input  logic          uart_rxd,
    output logic          uart_txd
);

    localparam int AW   = (TX_DEPTH > 1) ? $clog2(TX_DEPTH) : 1;
    localparam int CNTW = $clog2(TX_DEPTH + 1);
    localparam int CW   = $clog2(CLKS_PER_BIT);
    localparam int BW   = (DW > 1) ? $clog2(DW) : 1;

    localparam logic [CW-1:0]   BAUD_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]   HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BW-1:0]   BIT_MAX   = BW'(DW - 1);
    localparam logic [CNTW-1:0] FIFO_FULL = CNTW'(TX_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    // Bus decode
    logic wr_data;
    logic rd_data;
    logic wr_clr;

    assign wr_data = uart_wr && (uart_addr == 2'd0);
    assign rd_data = uart_rd && (uart_addr == 2'd0);
    assign wr_clr  = uart_wr && (uart_addr == 2'd2);

    // TX FIFO
    logic [DW-1:0]   fifo_mem [TX_DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CNTW-1:0] count;
    logic            tx_full;
    logic            tx_empty;
    logic            tx_push;
    logic            tx_pop;
    logic            tx_ovf;

    // TX FSM
    state_t        tx_state;
    logic [CW-1:0] tx_cnt;
    logic [BW-1:0] tx_bit;
    logic [DW-1:0] tx_shift;
    logic          tx_busy;

    assign tx_full  = (count == FIFO_FULL);
    assign tx_empty = (count == '0);
    assign tx_busy  = (tx_state != S_IDLE);

    // Full is judged on the pre-edge count, so a same-cycle pop
    // never makes room for a write.
    assign tx_push = wr_data && !tx_full;
    assign tx_pop  = !tx_empty &&
                     ((tx_state == S_IDLE) ||
                      (tx_state == S_STOP && tx_cnt == '0));

    always_ff @(posedge clk) begin
        if (tx_push) begin
            fifo_mem[wr_ptr] <= uart_din;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            tx_ovf <= 1'b0;
        end else begin
            if (tx_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (tx_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (tx_push && !tx_pop) begin
                count <= count + 1'b1;
            end else if (!tx_push && tx_pop) begin
                count <= count - 1'b1;
            end
            // Set beats a same-cycle clear.
            tx_ovf <= (wr_data && tx_full) ||
                      (tx_ovf && !(wr_clr && uart_din[6]));
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_state <= S_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
            uart_txd <= 1'b1;
        end else begin
            unique case (tx_state)
                S_IDLE: begin
                    uart_txd <= 1'b1;
                    if (tx_pop) begin
                        tx_shift <= fifo_mem[rd_ptr];
                        tx_cnt   <= BAUD_LAST;
                        uart_txd <= 1'b0;
                        tx_state <= S_START;
                    end
                end
                S_START: begin
                    if (tx_cnt == '0) begin
                        tx_cnt   <= BAUD_LAST;
                        tx_bit   <= '0;
                        uart_txd <= tx_shift[0];
                        tx_shift <= tx_shift >> 1;
                        tx_state <= S_DATA;
                    end else begin
                        tx_cnt <= tx_cnt - 1'b1;
                    end
                end
                S_DATA: begin
                    if (tx_cnt == '0) begin
                        tx_cnt <= BAUD_LAST;
                        tx_bit <= tx_bit + 1'b1;
                        if (tx_bit == BIT_MAX) begin
                            uart_txd <= 1'b1;
                            tx_state <= S_STOP;
                        end else begin
                            uart_txd <= tx_shift[0];
                            tx_shift <= tx_shift >> 1;
                        end
                    end else begin
                        tx_cnt <= tx_cnt - 1'b1;
                    end
                end
                S_STOP: begin
                    if (tx_cnt == '0) begin
                        // Back-to-back frames when more data is queued.
                        if (tx_pop) begin
                            tx_shift <= fifo_mem[rd_ptr];
                            tx_cnt   <= BAUD_LAST;
                            uart_txd <= 1'b0;
                            tx_state <= S_START;
                        end else begin
                            uart_txd <= 1'b1;
                            tx_state <= S_IDLE;
                        end
                    end else begin
                        tx_cnt <= tx_cnt - 1'b1;
                    end
                end
                default: begin
                    uart_txd <= 1'b1;
                    tx_state <= S_IDLE;
                end
            endcase
        end
    end

    // RX path
    logic          rx_s1;
    logic          rx_s2;
    state_t        rx_state;
    logic [CW-1:0] rx_cnt;
    logic [BW-1:0] rx_bit;
    logic [DW-1:0] rx_shift;
    logic          rx_valid;
    logic          rx_ovr;
    logic          frm_err;
    logic          stop_evt;
    logic          rx_good;
    logic          rx_bad;
    logic          rx_load;
    logic          ovr_set;

    assign stop_evt = (rx_state == S_STOP) && (rx_cnt == '0);
    assign rx_good  = stop_evt && rx_s2;
    assign rx_bad   = stop_evt && !rx_s2;
    // A pop in the accepting cycle frees the holding register.
    assign rx_load  = rx_good && (!rx_valid || rd_data);
    assign ovr_set  = rx_good && !rx_load;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
        end else begin
            rx_s1 <= uart_rxd;
            rx_s2 <= rx_s1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_state  <= S_IDLE;
            rx_cnt    <= '0;
            rx_bit    <= '0;
            rx_shift  <= '0;
            rx_valid  <= 1'b0;
            rx_ovr    <= 1'b0;
            frm_err   <= 1'b0;
            uart_dout <= '0;
        end else begin
            unique case (rx_state)
                S_IDLE: begin
                    if (!rx_s2) begin
                        rx_cnt   <= HALF_LAST;
                        rx_state <= S_START;
                    end
                end
                S_START: begin
                    if (rx_cnt == '0) begin
                        // High at mid start bit: glitch, re-arm.
                        if (rx_s2) begin
                            rx_state <= S_IDLE;
                        end else begin
                            rx_cnt   <= BAUD_LAST;
                            rx_bit   <= '0;
                            rx_state <= S_DATA;
                        end
                    end else begin
                        rx_cnt <= rx_cnt - 1'b1;
                    end
                end
                S_DATA: begin
                    if (rx_cnt == '0) begin
                        rx_cnt   <= BAUD_LAST;
                        rx_shift <= {rx_s2, rx_shift[DW-1:1]};
                        rx_bit   <= rx_bit + 1'b1;
                        if (rx_bit == BIT_MAX) begin
                            rx_state <= S_STOP;
                        end
                    end else begin
                        rx_cnt <= rx_cnt - 1'b1;
                    end
                end
                S_STOP: begin
                    if (rx_cnt == '0) begin
                        rx_state <= S_IDLE;
                    end else begin
                        rx_cnt <= rx_cnt - 1'b1;
                    end
                end
                default: rx_state <= S_IDLE;
            endcase

            if (rx_load) begin
                uart_dout <= rx_shift;
                rx_valid  <= 1'b1;
            end else if (rd_data) begin
                rx_valid <= 1'b0;
            end

            rx_ovr  <= ovr_set || (rx_ovr && !(wr_clr && uart_din[4]));
            frm_err <= rx_bad || (frm_err && !(wr_clr && uart_din[5]));
        end
    end

    // Decoded purely from registered state; no input-to-output path.
    assign uart_dout1 = DW'({tx_ovf, frm_err, rx_ovr, tx_busy,
                             tx_empty, tx_full, rx_valid});

endmodule

// File: tb/tb_uart_periph.sv
// Self-checking bench for uart_periph: queue-based reference model
// compared every cycle, directed scenarios plus a randomized phase.
module tb_uart_periph;

    localparam int C = 16;
    localparam int D = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       uart_rd = 1'b0;
    logic       uart_wr = 1'b0;
    logic [1:0] uart_addr = 2'd0;
    logic [7:0] uart_din = 8'd0;
    logic [7:0] uart_dout;
    logic [7:0] uart_dout1;
    logic       uart_rxd = 1'b1;
    logic       uart_txd;

    uart_periph #(
        .CLKS_PER_BIT(C),
        .TX_DEPTH(D),
        .DW(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .uart_rd(uart_rd),
        .uart_wr(uart_wr),
        .uart_addr(uart_addr),
        .uart_din(uart_din),
        .uart_dout(uart_dout),
        .uart_dout1(uart_dout1),
        .uart_rxd(uart_rxd),
        .uart_txd(uart_txd)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int last_ev_at = 0;

    typedef struct {
        int         at;
        logic [7:0] b;
        bit         stop;
    } rx_ev_t;

    // Reference model state
    logic [7:0] q[$];
    rx_ev_t     evq[$];
    bit         m_busy = 0;
    int         m_fstart = 0;
    logic [7:0] m_fbyte = 0;
    bit         m_valid = 0;
    bit         m_ovr = 0;
    bit         m_ferr = 0;
    bit         m_ovf = 0;
    logic [7:0] m_dout = 0;

    int         m_pre;
    bit         m_wr0, m_rd0, m_clr, m_ld, m_ovr_s, m_fe_s, m_ovf_s;
    rx_ev_t     m_ev;

    task automatic check(input string name, input logic [7:0] got,
                         input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %02h expected %02h (cycle %0d)",
                     name, got, exp, cyc);
        end
    endtask

    // Expected line level: frame = start, 8 data LSB first, stop,
    // each C cycles, starting on the edge the byte was popped.
    function automatic logic m_txd();
        int d;
        if (!m_busy) return 1'b1;
        d = cyc - m_fstart;
        if (d < C) return 1'b0;
        if (d < 9 * C) return m_fbyte[d / C - 1];
        return 1'b1;
    endfunction

    function automatic logic [7:0] m_status();
        return {1'b0, m_ovf, m_ferr, m_ovr, m_busy,
                q.size() == 0, q.size() == D, m_valid};
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            q.delete();
            evq.delete();
            m_busy = 0;
            m_valid = 0;
            m_ovr = 0;
            m_ferr = 0;
            m_ovf = 0;
            m_dout = 8'h00;
        end else begin
            cyc++;
            m_pre = q.size();
            m_wr0 = uart_wr && uart_addr == 2'd0;
            m_rd0 = uart_rd && uart_addr == 2'd0;
            m_clr = uart_wr && uart_addr == 2'd2;
            if (m_busy && cyc == m_fstart + 10 * C) begin
                if (m_pre > 0) begin
                    m_fbyte = q.pop_front();
                    m_fstart = cyc;
                end else begin
                    m_busy = 0;
                end
            end else if (!m_busy && m_pre > 0) begin
                m_fbyte = q.pop_front();
                m_fstart = cyc;
                m_busy = 1;
            end
            m_ovf_s = m_wr0 && m_pre == D;
            if (m_wr0 && m_pre < D) q.push_back(uart_din);
            m_ld = 0;
            m_ovr_s = 0;
            m_fe_s = 0;
            if (evq.size() > 0 && evq[0].at == cyc) begin
                m_ev = evq.pop_front();
                if (m_ev.stop) begin
                    if (!m_valid || m_rd0) begin
                        m_ld = 1;
                        m_dout = m_ev.b;
                    end else begin
                        m_ovr_s = 1;
                    end
                end else begin
                    m_fe_s = 1;
                end
            end
            if (m_ld) m_valid = 1;
            else if (m_rd0) m_valid = 0;
            m_ovr = m_ovr_s || (m_ovr && !(m_clr && uart_din[4]));
            m_ferr = m_fe_s || (m_ferr && !(m_clr && uart_din[5]));
            m_ovf = m_ovf_s || (m_ovf && !(m_clr && uart_din[6]));
        end
    end

    always @(negedge clk) begin
        check("txd", {7'b0, uart_txd}, {7'b0, m_txd()});
        check("dout", uart_dout, m_dout);
        check("status", uart_dout1, m_status());
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus(input bit rd, input bit wr, input logic [1:0] a,
                       input logic [7:0] d);
        uart_rd = rd;
        uart_wr = wr;
        uart_addr = a;
        uart_din = d;
        wait_cyc(1);
        uart_rd = 1'b0;
        uart_wr = 1'b0;
    endtask

    // Stop sample lands 2 sync flops + 1 detect + half bit + 9 bits
    // after the start bit is driven.
    task automatic send_rx(input logic [7:0] b, input bit stop);
        rx_ev_t ev;
        logic [9:0] fr;
        fr = {stop, b, 1'b0};
        ev.at = cyc + 3 + C / 2 + 9 * C;
        ev.b = b;
        ev.stop = stop;
        evq.push_back(ev);
        last_ev_at = ev.at;
        for (int i = 0; i < 10; i++) begin
            uart_rxd = fr[i];
            wait_cyc(C);
        end
        uart_rxd = 1'b1;
        if (!stop) wait_cyc(C);
    endtask

    task automatic wait_idle(input int budget);
        int k;
        k = 0;
        while (!(uart_dout1[2] && !uart_dout1[3]) && k < budget) begin
            wait_cyc(1);
            k++;
        end
        n_cmp++;
        if (k >= budget) begin
            n_bad++;
            $display("FAIL drain_timeout: status %02h after %0d cycles",
                     uart_dout1, k);
        end
    endtask

    logic [9:0] p55;
    logic [31:0] r;

    initial begin
        p55 = 10'b1010101010;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        wait_cyc(2);
        check("rst_status", uart_dout1, 8'h04);
        check("rst_txd", {7'b0, uart_txd}, 8'h01);
        check("rst_dout", uart_dout, 8'h00);

        // Single frame 0x55
        bus(0, 1, 2'd0, 8'h55);
        check("t1_wr_status", uart_dout1, 8'h00);
        wait_cyc(9);
        for (int j = 0; j < 10; j++) begin
            check("t1_bit", {7'b0, uart_txd}, {7'b0, p55[j]});
            check("t1_status", uart_dout1, 8'h0C);
            wait_cyc(C);
        end
        wait_cyc(C);
        check("t1_idle", uart_dout1, 8'h04);

        // Six back-to-back writes, the sixth is dropped
        for (int i = 1; i <= 6; i++) bus(0, 1, 2'd0, 8'(i));
        check("t2_full_ovf", uart_dout1, 8'h4A);
        wait_idle(3000);
        check("t2_drained", uart_dout1, 8'h44);
        bus(0, 1, 2'd2, 8'h40);
        check("t2_clr", uart_dout1, 8'h04);

        // RX receive and overrun
        send_rx(8'hA3, 1);
        check("t3_dout", uart_dout, 8'hA3);
        check("t3_valid", uart_dout1, 8'h05);
        send_rx(8'h3C, 1);
        check("t3_ovr_dout", uart_dout, 8'hA3);
        check("t3_ovr", uart_dout1, 8'h15);
        bus(1, 0, 2'd0, 8'h00);
        check("t3_pop", uart_dout1, 8'h14);
        bus(0, 1, 2'd2, 8'h10);
        check("t3_clr", uart_dout1, 8'h04);

        // Framing error, glitch, then a good frame
        send_rx(8'h7E, 0);
        check("t4_ferr", uart_dout1, 8'h24);
        uart_rxd = 1'b0;
        wait_cyc(5);
        uart_rxd = 1'b1;
        wait_cyc(3 * C);
        check("t4_glitch", uart_dout1, 8'h24);
        send_rx(8'h81, 1);
        check("t4_dout", uart_dout, 8'h81);
        check("t4_status", uart_dout1, 8'h25);
        bus(0, 1, 2'd2, 8'h20);

        // Reset mid TX bit 3 and mid RX data
        bus(0, 1, 2'd0, 8'h5A);
        uart_rxd = 1'b0;
        wait_cyc(4 * C + 8);
        rst = 1'b0;
        #1;
        check("t5_txd", {7'b0, uart_txd}, 8'h01);
        check("t5_status", uart_dout1, 8'h04);
        check("t5_dout", uart_dout, 8'h00);
        uart_rxd = 1'b1;
        wait_cyc(3);
        rst = 1'b1;
        wait_cyc(2);
        bus(0, 1, 2'd0, 8'h0F);
        wait_cyc(11 * C);
        check("t5_after", uart_dout1, 8'h04);

        // Pop exactly on the stop-accept edge
        send_rx(8'h11, 1);
        check("t6_first", uart_dout1, 8'h05);
        fork
            send_rx(8'h22, 1);
        join_none
        wait_cyc(1);
        while (cyc < last_ev_at - 1) wait_cyc(1);
        uart_rd = 1'b1;
        uart_addr = 2'd0;
        wait_cyc(1);
        uart_rd = 1'b0;
        check("t6_dout", uart_dout, 8'h22);
        check("t6_status", uart_dout1, 8'h05);
        wait_cyc(C);

        // Randomized traffic on both sides
        for (int it = 0; it < 30; it++) begin
            fork
                send_rx(8'($urandom), ($urandom % 5) != 0);
                begin
                    for (int k = 0; k < 10 * C + 20; k++) begin
                        r = $urandom;
                        uart_rd = r[2:0] == 3'd0;
                        uart_wr = r[5:3] < 3'd2;
                        uart_addr = r[7:6];
                        uart_din = r[15:8];
                        wait_cyc(1);
                    end
                    uart_rd = 1'b0;
                    uart_wr = 1'b0;
                end
            join
        end
        wait_idle(3000);
        wait_cyc(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
